// File: rtl/alu_share_ctrl_if.sv
// Request, grant and result bundle between two ALU requesters, the shared controller and the result sink.
interface alu_share_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0;
  logic             req1;
  logic [2:0]       op0;
  logic [2:0]       op1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;
  logic             res_zero;
  logic             busy;

  // Requester and consumer side
  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, res_ready,
    input  gnt0, gnt1, res_valid, res_id, res_data, res_carry, res_zero, busy
  );

  // Controller side
  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, res_ready,
    output gnt0, gnt1, res_valid, res_id, res_data, res_carry, res_zero, busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin shared ALU controller: grants one of two requesters, executes the op
// (shifts iterate one bit per cycle) and holds a tagged result until accepted.
module alu_share_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_share_ctrl_if.slave  bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             last_id_q, last_id_d;
  logic             id_q, id_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_carry_q, res_carry_d;
  logic             res_zero_q, res_zero_d;
  logic             res_id_q, res_id_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;

  logic             pick1_c;
  logic             grant_c;
  logic             gnt0_c;
  logic             gnt1_c;
  logic             is_shift_c;
  logic             shift_go_c;
  logic [SHW-1:0]   amt_c;
  logic [WIDTH:0]   alu_c;
  logic [WIDTH-1:0] shifted_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_c) state_d = S_EXEC;
      S_EXEC:  state_d = shift_go_c ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt_q == SHW'(1)) state_d = S_DONE;
      S_DONE:  if (bus.res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant outputs: only in IDLE, tie goes to the requester not served last
  always_comb begin
    pick1_c = bus.req1 & (~bus.req0 | ~last_id_q);
    grant_c = rst_n & (state_q == S_IDLE) & (bus.req0 | bus.req1);
    gnt0_c  = grant_c & ~pick1_c;
    gnt1_c  = grant_c & pick1_c;
  end

  // Single-cycle ALU on latched operands plus one-bit shifter step
  always_comb begin
    is_shift_c = op_q[2] & op_q[1];
    amt_c      = b_q[SHW-1:0];
    shift_go_c = is_shift_c & (amt_c != '0);
    shifted_c  = op_q[0] ? (work_q >> 1) : (work_q << 1);
    case (op_q)
      OP_ADD:  alu_c = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  alu_c = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
      OP_AND:  alu_c = {1'b0, a_q & b_q};
      OP_OR:   alu_c = {1'b0, a_q | b_q};
      OP_XOR:  alu_c = {1'b0, a_q ^ b_q};
      OP_NOT:  alu_c = {1'b0, ~a_q};
      default: alu_c = {1'b0, a_q};  // shift by zero passes a through
    endcase
  end

  // Datapath next values: operand capture, shift iteration, result write
  always_comb begin
    last_id_d   = last_id_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_zero_d  = res_zero_q;
    res_id_d    = res_id_q;
    res_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (grant_c) begin
          id_d      = pick1_c;
          last_id_d = pick1_c;
          op_d      = pick1_c ? bus.op1 : bus.op0;
          a_d       = pick1_c ? bus.a1  : bus.a0;
          b_d       = pick1_c ? bus.b1  : bus.b0;
        end
      end
      S_EXEC: begin
        if (shift_go_c) begin
          work_d = a_q;
          cnt_d  = amt_c;
        end else begin
          res_data_d  = alu_c[WIDTH-1:0];
          res_carry_d = alu_c[WIDTH];
          res_zero_d  = (alu_c[WIDTH-1:0] == '0);
          res_id_d    = id_q;
        end
      end
      S_SHIFT: begin
        work_d = shifted_c;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          res_data_d  = shifted_c;
          res_carry_d = 1'b0;
          res_zero_d  = (shifted_c == '0);
          res_id_d    = id_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_id_q   <= 1'b1;
      id_q        <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
      res_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      last_id_q   <= last_id_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_zero_q  <= res_zero_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt0      = gnt0_c;
  assign bus.gnt1      = gnt1_c;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = busy_q;
endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Controller that shares one WIDTH-bit ALU datapath (ADD, SUB, AND, OR, XOR, NOT, and iterative shift-left/right) between two requesters. It grants requesters round-robin, latches the winner's operands, sequences execution, and holds a tagged result with flags until the consumer accepts it. It sits between the two requesting units and the ALU result sink.

## Interface
- WIDTH, 32, operand/result width; shift amount is b[$clog2(WIDTH)-1:0]
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0 / req1  in  1  request; held with operands stable until matching grant
- op0 / op1  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT (~a), 110 SHL, 111 SHR (logical)
- a0, b0 / a1, b1  in  WIDTH  operands
- gnt0 / gnt1  out  1  one-cycle grant; operands captured on this edge
- res_valid  out  1  result held valid
- res_ready  in  1  consumer accepts result
- res_id  out  1  requester index of result
- res_data  out  WIDTH  result
- res_carry  out  1  carry-out (ADD), a+~b+1 carry-out (SUB, 1 = no borrow), else 0
- res_zero  out  1  res_data == 0
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, SHIFT, DONE.
- IDLE: gnt combinational. One requester -> it wins. Both -> winner is the index != last_id. Edge with gnt: latch op/a/b/id, last_id <= id, -> EXEC. No req -> stay.
- EXEC, non-shift op: compute, register res_data/flags/res_id, -> DONE.
- EXEC, shift op: amount 0 -> res_data = a, -> DONE; else work <= a, cnt <= amount, -> SHIFT.
- SHIFT: each cycle work shifts 1 bit (zero fill), cnt decrements; edge with cnt == 1 writes final value to res_data, -> DONE.
- DONE: res_valid = 1; res_data/flags/id stable. Edge with res_ready -> IDLE. No grants in EXEC, SHIFT, or DONE.
- ADD/SUB wrap modulo 2^WIDTH. NOT ignores b. Shift amount uses only the low $clog2(WIDTH) bits of b.
- res_ready is ignored outside DONE. A request dropped before grant is forgotten.
- Reset values: state IDLE; res_valid 0, res_data 0, res_id 0, res_carry 0, res_zero 0, busy 0; gnt0/gnt1 0 while rst_n low; last_id 1, so requester 0 wins the first tie.
- Reset mid-operation: the operation is discarded. No result is produced and the requester is not re-granted.

## Timing
- Grant cycle = cycle 0 (IDLE, gnt high).
- Non-shift op, or shift by 0: EXEC at cycle 1, res_valid high from cycle 2.
- Shift by n>0: EXEC at cycle 1, SHIFT at cycles 2..n+1, res_valid high from cycle n+2.
- Result consumed at the edge ending a DONE cycle with res_ready=1. The next grant can occur in the following cycle (IDLE).
- Minimum op-to-op spacing is 3 cycles.

## Test plan
- Reset: rst_n low 2 cycles with req0=1 -> gnt0=0, res_valid=0, busy=0 throughout. After release, gnt0 is high in the first IDLE cycle.
- ADD req0 a=0xFFFFFFFF b=1 -> gnt0 at cycle 0; res_valid at cycle 2 with data 0, carry 1, zero 1, id 0. SUB a=5 b=5 -> 0, carry 1, zero 1. NOT a=0 -> 0xFFFFFFFF, carry 0.
- req0 and req1 held continuously from reset, res_ready=1 -> grants alternate 0,1,0,1, and res_id alternates to match.
- SHL a=1 b=5 -> res 0x20 valid at cycle 7. SHL b=0 -> res = a at cycle 2. SHR a=0x80000000 b=31 -> 0x1 at cycle 33. b=0x25 (WIDTH 32) -> shift by 5.
- Backpressure: hold res_ready=0 for 5 cycles in DONE with req1 pending -> res_valid and data stable, gnt1=0. Raise res_ready -> IDLE next cycle with gnt1=1.
- Assert rst_n=0 during SHIFT of a 20-bit shift -> next cycle busy=0, res_valid=0. No result appears after release.
